bcd_scan_display: RTL and testbench

Parametrised, time-multiplexed N-digit BCD-to-seven-segment display driver. It generalises the single-digit combinational BCD decoder into a sequential block that refreshes several digits. The block holds a packed BCD word, scans one digit per refresh period, and drives shared active-low segment lines plus per-digit active-low anode enables. It sits between the counter/arithmetic logic and the board's seven-segment pins. Loaded values are double-buffered, so a digit never changes mid-frame.

---
 rtl/bcd_scan_display_if.sv | 23 ++
 rtl/bcd_scan_display.sv | 128 ++++++++++++
 tb/tb_bcd_scan_display.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/bcd_scan_display_if.sv
// rtl/bcd_scan_display_if.sv - load/data/blank inputs and scanned display outputs of the BCD scan driver
interface bcd_scan_display_if #(
    parameter int DIGITS = 4
);
    logic                  load;
    logic [4*DIGITS-1:0]   bcd_in;
    logic [DIGITS-1:0]     dp_in;
    logic                  blank;
    logic [6:0]            seg;
    logic                  dp;
    logic [DIGITS-1:0]     an;
    logic                  frame;

    modport master (
        output load, bcd_in, dp_in, blank,
        input  seg, dp, an, frame
    );

    modport slave (
        input  load, bcd_in, dp_in, blank,
        output seg, dp, an, frame
    );
endinterface

// File: rtl/bcd_scan_display.sv
// rtl/bcd_scan_display.sv - time-multiplexed N-digit BCD seven-segment driver, double-buffered
// Optional leading-zero blanking when BCD_SCAN_LZB_EN is defined.
module bcd_scan_display #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic              clk,
    input  logic              rst,
    bcd_scan_display_if.slave bus
);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [PW-1:0]         r_presc;
    logic [IW-1:0]         r_idx;
    logic [4*DIGITS-1:0]   r_pend_bcd;
    logic [DIGITS-1:0]     r_pend_dp;
    logic [4*DIGITS-1:0]   r_act_bcd;
    logic [DIGITS-1:0]     r_act_dp;
    logic [6:0]            r_seg;
    logic                  r_dp;
    logic [DIGITS-1:0]     r_an;
    logic                  r_frame;

    logic                  w_tc;
    logic                  w_wrap;
    logic [3:0]            w_nib;
    logic                  w_dp_sel;
    logic                  w_lz_sel;
    logic [DIGITS-1:0]     w_lz;
    logic [DIGITS-1:0]     w_an;

    function automatic logic [6:0] f_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    assign w_tc   = (r_presc == PW'(REFRESH_DIV - 1));
    // With one digit the index never leaves 0, so every terminal count is a wrap.
    assign w_wrap = w_tc && (r_idx == IW'(DIGITS - 1));

`ifdef BCD_SCAN_LZB_EN
    always_comb begin
        logic z;
        z    = 1'b1;
        w_lz = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            z = z & (r_act_bcd[4*k +: 4] == 4'd0);
            w_lz[k] = z && (k != 0);
        end
    end
`else
    assign w_lz = '0;
`endif

    always_comb begin
        w_nib    = 4'd0;
        w_dp_sel = 1'b0;
        w_lz_sel = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_idx == IW'(k)) begin
                w_nib    = r_act_bcd[4*k +: 4];
                w_dp_sel = r_act_dp[k];
                w_lz_sel = w_lz[k];
            end
        end
    end

    always_comb begin
        w_an = '1;
        for (int k = 0; k < DIGITS; k++) begin
            w_an[k] = bus.blank | (r_idx != IW'(k));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc    <= '0;
            r_idx      <= '0;
            r_pend_bcd <= '0;
            r_pend_dp  <= '0;
            r_act_bcd  <= '0;
            r_act_dp   <= '0;
            r_seg      <= 7'h7F;
            r_dp       <= 1'b1;
            r_an       <= '1;
            r_frame    <= 1'b0;
        end else begin
            r_presc <= w_tc ? '0 : r_presc + PW'(1);
            if (w_wrap) begin
                r_idx <= '0;
            end else if (w_tc) begin
                r_idx <= r_idx + IW'(1);
            end
            if (bus.load) begin
                r_pend_bcd <= bus.bcd_in;
                r_pend_dp  <= bus.dp_in;
            end
            // A load landing on the wrap edge bypasses pending straight into active.
            if (w_wrap) begin
                r_act_bcd <= bus.load ? bus.bcd_in : r_pend_bcd;
                r_act_dp  <= bus.load ? bus.dp_in  : r_pend_dp;
            end
            r_frame <= w_wrap;
            r_seg   <= w_lz_sel ? 7'h7F : f_decode(w_nib);
            r_dp    <= ~w_dp_sel;
            r_an    <= w_an;
        end
    end

    assign bus.seg   = r_seg;
    assign bus.dp    = r_dp;
    assign bus.an    = r_an;
    assign bus.frame = r_frame;
endmodule

// File: tb/tb_bcd_scan_display.sv
// tb/tb_bcd_scan_display.sv - scoreboard bench for bcd_scan_display, DIGITS=4 REFRESH_DIV=4
module tb_bcd_scan_display;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   epoch = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    event ev_chk;

`ifdef BCD_SCAN_LZB_EN
    localparam logic [6:0] LZ = 7'h7F;
`else
    localparam logic [6:0] LZ = 7'h40;
`endif

    typedef struct {
        int         ep;
        int         cyc;
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
        logic       frame;
    } exp_t;

    exp_t q[$];
    exp_t rq[$];

    bcd_scan_display_if #(.DIGITS(4)) bus ();

    bcd_scan_display #(.DIGITS(4), .REFRESH_DIV(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic compare(input exp_t e, input string name);
        n_checks++;
        if (bus.seg === e.seg && bus.dp === e.dp && bus.an === e.an && bus.frame === e.frame)
            n_pass++;
        else
            $display("FAIL %s ep%0d cyc%0d: got seg=%h dp=%b an=%b frame=%b, need seg=%h dp=%b an=%b frame=%b",
                     name, e.ep, e.cyc, bus.seg, bus.dp, bus.an, bus.frame, e.seg, e.dp, e.an, e.frame);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            while (q.size() > 0 && (q[0].ep < epoch || (q[0].ep == epoch && q[0].cyc < cyc))) begin
                e = q.pop_front();
                n_checks++;
                $display("FAIL missed ep%0d cyc%0d: got no sample, need one", e.ep, e.cyc);
            end
            if (q.size() > 0 && q[0].ep == epoch && q[0].cyc == cyc) begin
                e = q.pop_front();
                compare(e, "scan");
            end
        end
    end

    always @(ev_chk) begin
        exp_t e;
        if (rq.size() > 0) begin
            e = rq.pop_front();
            compare(e, "reset");
        end
    end

    task automatic push_range(input int ep, input int a, input int b,
                              input logic [6:0] seg, input logic dp, input logic [3:0] an);
        for (int c = a; c <= b; c++) begin
            exp_t e;
            e.ep = ep; e.cyc = c; e.seg = seg; e.dp = dp; e.an = an;
            e.frame = (c % 16 == 0);
            q.push_back(e);
        end
    endtask

    task automatic wait_cyc(input int n);
        int b;
        b = 0;
        while (cyc != n && b < 2000) begin
            @(negedge clk);
            b++;
        end
        if (cyc != n) begin
            n_checks++;
            $display("FAIL timeout: got cyc=%0d, need cyc=%0d", cyc, n);
        end
    endtask

    task automatic do_load(input int edge_n, input logic [15:0] v, input logic [3:0] d);
        wait_cyc(edge_n - 1);
        bus.load   = 1'b1;
        bus.bcd_in = v;
        bus.dp_in  = d;
        wait_cyc(edge_n);
        bus.load   = 1'b0;
    endtask

    initial begin
        exp_t r;
        bus.load   = 1'b0;
        bus.bcd_in = '0;
        bus.dp_in  = '0;
        bus.blank  = 1'b0;
        repeat (3) @(negedge clk);
        r.ep = 0; r.cyc = 0; r.seg = 7'h7F; r.dp = 1'b1; r.an = 4'hF; r.frame = 1'b0;
        rq.push_back(r);
        -> ev_chk;
        #1;
        @(negedge clk);
        rst = 1'b0;

        push_range(0,   1,   4, 7'h40, 1'b1, 4'hE);
        push_range(0,   5,   8, 7'h40, 1'b1, 4'hD);
        push_range(0,   9,  12, 7'h40, 1'b1, 4'hB);
        push_range(0,  13,  16, 7'h40, 1'b1, 4'h7);
        push_range(0,  17,  20, 7'h19, 1'b1, 4'hE);
        push_range(0,  21,  24, 7'h30, 1'b1, 4'hD);
        push_range(0,  25,  28, 7'h24, 1'b1, 4'hB);
        push_range(0,  29,  32, 7'h79, 1'b1, 4'h7);
        push_range(0,  33,  36, 7'h10, 1'b1, 4'hE);
        push_range(0,  37,  40, 7'h3F, 1'b1, 4'hD);
        push_range(0,  41,  44, 7'h40, 1'b1, 4'hB);
        push_range(0,  45,  48, 7'h3F, 1'b1, 4'h7);
        push_range(0,  49,  52, 7'h40, 1'b1, 4'hE);
        push_range(0,  53,  56, 7'h12, 1'b1, 4'hD);
        push_range(0,  57,  60, LZ,    1'b1, 4'hB);
        push_range(0,  61,  64, LZ,    1'b1, 4'h7);
        push_range(0,  65,  68, 7'h40, 1'b1, 4'hE);
        push_range(0,  69,  72, LZ,    1'b1, 4'hD);
        push_range(0,  73,  76, LZ,    1'b1, 4'hB);
        push_range(0,  77,  80, LZ,    1'b1, 4'h7);
        push_range(0,  81,  84, 7'h12, 1'b1, 4'hE);
        push_range(0,  85,  88, 7'h02, 1'b1, 4'hD);
        push_range(0,  89,  92, 7'h78, 1'b0, 4'hB);
        push_range(0,  93,  96, 7'h00, 1'b1, 4'h7);
        push_range(0,  97, 100, 7'h12, 1'b1, 4'hF);
        push_range(0, 101, 104, 7'h02, 1'b1, 4'hF);
        push_range(0, 105, 106, 7'h78, 1'b0, 4'hF);
        push_range(0, 107, 108, 7'h78, 1'b0, 4'hB);
        push_range(0, 109, 112, 7'h00, 1'b1, 4'h7);

        do_load(6,  16'h1234, 4'b0000);
        do_load(32, 16'hF0A9, 4'b0000);
        do_load(48, 16'h0050, 4'b0000);
        do_load(64, 16'h0000, 4'b0000);
        do_load(80, 16'h8765, 4'b0100);
        wait_cyc(96);
        bus.blank = 1'b1;
        wait_cyc(106);
        bus.blank = 1'b0;

        wait_cyc(121);
        #3;
        epoch = 1;
        rst = 1'b1;
        #1;
        r.ep = 1; r.cyc = 0; r.seg = 7'h7F; r.dp = 1'b1; r.an = 4'hF; r.frame = 1'b0;
        rq.push_back(r);
        -> ev_chk;
        push_range(1, 1, 4, 7'h40, 1'b1, 4'hE);
        push_range(1, 5, 5, 7'h40, 1'b1, 4'hD);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_cyc(20);

        n_checks++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL leftover: got %0d pending expectations, need 0", q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
